// File: rtl/ddr4_v2_2_24_tg_sched_pkg.sv
// rtl/ddr4_v2_2_24_tg_sched_pkg.sv - shared types for the TG write/read scheduler
package ddr4_v2_2_24_tg_sched_pkg;

    localparam logic [1:0] SCHED_IDLE = 2'd0;
    localparam logic [1:0] SCHED_WR   = 2'd1;
    localparam logic [1:0] SCHED_RD   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = SCHED_IDLE,
        ST_WR   = SCHED_WR,
        ST_RD   = SCHED_RD
    } sched_state_e;

endpackage

// File: rtl/ddr4_v2_2_24_tg_sched_cnt.sv
// rtl/ddr4_v2_2_24_tg_sched_cnt.sv - clearable, enabled, saturating up-counter
module ddr4_v2_2_24_tg_sched_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ddr4_v2_2_24_tg_rw_scheduler.sv
// rtl/ddr4_v2_2_24_tg_rw_scheduler.sv - merges a write-only and a read-only
// requester onto the MC UI using bounded bursts and a starvation timer
module ddr4_v2_2_24_tg_rw_scheduler
    import ddr4_v2_2_24_tg_sched_pkg::*;
#(
    parameter int TCQ            = 100,
    parameter int APP_ADDR_WIDTH = 32,
    parameter int APP_CMD_WIDTH  = 3,
    parameter int APP_DATA_WIDTH = 32,
    parameter int DM_WIDTH       = 8,
    parameter int CNT_WIDTH      = 8,
    parameter int MW             = APP_DATA_WIDTH / DM_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_calib_complete_r,
    input  logic [CNT_WIDTH-1:0]      wr_burst_max,
    input  logic [CNT_WIDTH-1:0]      rd_burst_max,
    input  logic [CNT_WIDTH-1:0]      starve_limit,
    input  logic                      wr_req_en,
    input  logic [APP_CMD_WIDTH-1:0]  wr_req_cmd,
    input  logic [APP_ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [APP_DATA_WIDTH-1:0] wr_req_data,
    input  logic [MW-1:0]             wr_req_mask,
    output logic                      wr_req_rdy,
    input  logic                      rd_req_en,
    input  logic [APP_CMD_WIDTH-1:0]  rd_req_cmd,
    input  logic [APP_ADDR_WIDTH-1:0] rd_req_addr,
    output logic                      rd_req_rdy,
    input  logic                      app_rdy,
    input  logic                      app_wdf_rdy,
    output logic                      app_en,
    output logic [APP_CMD_WIDTH-1:0]  app_cmd,
    output logic [APP_ADDR_WIDTH-1:0] app_addr,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic [MW-1:0]             app_wdf_mask,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [1:0]                sched_state
);

    // Clock-to-q is a simulation-only notion in the original flow; only sanity-check it here.
    if (TCQ < 0) begin : g_tcq_invalid
    end

    sched_state_e        state_q, state_d;
    logic                last_wr_q, last_wr_d;
    logic                restart;
    logic                wr_xfer, rd_xfer;
    logic                cnt_clr, burst_en, starve_en;
    logic [CNT_WIDTH-1:0] burst_cnt, starve_cnt;
    logic [CNT_WIDTH-1:0] wr_lim, rd_lim;
    logic [CNT_WIDTH:0]   burst_nxt;
    logic                 wr_done, rd_done, starve_hit;

    assign wr_xfer = init_calib_complete_r && (state_q == ST_WR) && wr_req_en && app_rdy && app_wdf_rdy;
    assign rd_xfer = init_calib_complete_r && (state_q == ST_RD) && rd_req_en && app_rdy;

    assign wr_lim     = (wr_burst_max == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : wr_burst_max;
    assign rd_lim     = (rd_burst_max == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : rd_burst_max;
    assign burst_nxt  = {1'b0, burst_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign wr_done    = wr_xfer && (burst_nxt >= {1'b0, wr_lim});
    assign rd_done    = rd_xfer && (burst_nxt >= {1'b0, rd_lim});
    assign starve_hit = (starve_limit != '0) && (starve_cnt >= starve_limit);

    // A finished burst with nobody waiting on the other side starts a fresh burst in place.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        if (!init_calib_complete_r) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_req_en && rd_req_en)
                        state_d = last_wr_q ? ST_RD : ST_WR;
                    else if (wr_req_en)
                        state_d = ST_WR;
                    else if (rd_req_en)
                        state_d = ST_RD;
                end
                ST_WR: begin
                    if (!wr_req_en || (starve_hit && rd_req_en))
                        state_d = rd_req_en ? ST_RD : ST_IDLE;
                    else if (wr_done) begin
                        if (rd_req_en) state_d = ST_RD;
                        else           restart = 1'b1;
                    end
                end
                ST_RD: begin
                    if (!rd_req_en || (starve_hit && wr_req_en))
                        state_d = wr_req_en ? ST_WR : ST_IDLE;
                    else if (rd_done) begin
                        if (wr_req_en) state_d = ST_WR;
                        else           restart = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        last_wr_d = last_wr_q;
        if (state_d == ST_WR)      last_wr_d = 1'b1;
        else if (state_d == ST_RD) last_wr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
        end
    end

    assign cnt_clr   = (state_d != state_q) || restart || !init_calib_complete_r;
    assign burst_en  = wr_xfer || rd_xfer;
    assign starve_en = ((state_q == ST_WR) && rd_req_en) || ((state_q == ST_RD) && wr_req_en);

    ddr4_v2_2_24_tg_sched_cnt #(.W(CNT_WIDTH)) u_burst_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (burst_en),
        .cnt_o (burst_cnt)
    );

    ddr4_v2_2_24_tg_sched_cnt #(.W(CNT_WIDTH)) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (starve_en),
        .cnt_o (starve_cnt)
    );

    assign wr_req_rdy   = (state_q == ST_WR) && app_rdy && app_wdf_rdy;
    assign rd_req_rdy   = (state_q == ST_RD) && app_rdy;
    assign app_en       = wr_xfer || rd_xfer;
    assign app_cmd      = (state_q == ST_WR) ? wr_req_cmd  : (state_q == ST_RD) ? rd_req_cmd  : '0;
    assign app_addr     = (state_q == ST_WR) ? wr_req_addr : (state_q == ST_RD) ? rd_req_addr : '0;
    assign app_wdf_data = wr_req_data;
    assign app_wdf_mask = wr_req_mask;
    assign app_wdf_wren = wr_xfer;
    assign app_wdf_end  = wr_xfer;
    assign sched_state  = state_q;

endmodule

// File: tb/tb_ddr4_v2_2_24_tg_rw_scheduler.sv
// tb/tb_ddr4_v2_2_24_tg_rw_scheduler.sv - directed self-checking bench for the TG rw scheduler
module tb_ddr4_v2_2_24_tg_rw_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_calib_complete_r;
    logic [7:0]  wr_burst_max, rd_burst_max, starve_limit;
    logic        wr_req_en;
    logic [2:0]  wr_req_cmd;
    logic [31:0] wr_req_addr, wr_req_data;
    logic [3:0]  wr_req_mask;
    logic        wr_req_rdy;
    logic        rd_req_en;
    logic [2:0]  rd_req_cmd;
    logic [31:0] rd_req_addr;
    logic        rd_req_rdy;
    logic        app_rdy, app_wdf_rdy;
    logic        app_en;
    logic [2:0]  app_cmd;
    logic [31:0] app_addr, app_wdf_data;
    logic [3:0]  app_wdf_mask;
    logic        app_wdf_wren, app_wdf_end;
    logic [1:0]  sched_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ddr4_v2_2_24_tg_rw_scheduler u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .init_calib_complete_r (init_calib_complete_r),
        .wr_burst_max          (wr_burst_max),
        .rd_burst_max          (rd_burst_max),
        .starve_limit          (starve_limit),
        .wr_req_en             (wr_req_en),
        .wr_req_cmd            (wr_req_cmd),
        .wr_req_addr           (wr_req_addr),
        .wr_req_data           (wr_req_data),
        .wr_req_mask           (wr_req_mask),
        .wr_req_rdy            (wr_req_rdy),
        .rd_req_en             (rd_req_en),
        .rd_req_cmd            (rd_req_cmd),
        .rd_req_addr           (rd_req_addr),
        .rd_req_rdy            (rd_req_rdy),
        .app_rdy               (app_rdy),
        .app_wdf_rdy           (app_wdf_rdy),
        .app_en                (app_en),
        .app_cmd               (app_cmd),
        .app_addr              (app_addr),
        .app_wdf_data          (app_wdf_data),
        .app_wdf_mask          (app_wdf_mask),
        .app_wdf_wren          (app_wdf_wren),
        .app_wdf_end           (app_wdf_end),
        .sched_state           (sched_state)
    );

    // Leaves the bench 1 time unit after the edge at which reset was sampled.
    task automatic do_reset();
        rst = 1'b1;
        init_calib_complete_r = 1'b1;
        wr_burst_max = 8'd4; rd_burst_max = 8'd2; starve_limit = 8'd0;
        wr_req_en = 1'b0; wr_req_cmd = 3'd0; wr_req_addr = 32'h0000_1000;
        wr_req_data = 32'hA5A5_0001; wr_req_mask = 4'h3;
        rd_req_en = 1'b0; rd_req_cmd = 3'd1; rd_req_addr = 32'h0000_2000;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (sched_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", sched_state); end
        checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL reset_app_en got=%b exp=0", app_en); end
        checks++; if (wr_req_rdy !== 1'b0 || rd_req_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b%b exp=00", wr_req_rdy, rd_req_rdy); end
        checks++; if (app_cmd !== 3'd0 || app_addr !== 32'd0) begin errors++; $display("FAIL reset_cmd_addr got=%0d/%h exp=0/0", app_cmd, app_addr); end
        checks++; if (app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b%b exp=00", app_wdf_wren, app_wdf_end); end
    endtask

    // 1 = WR cycle, 0 = RD cycle, MSB first
    task automatic run_pattern(input string name, input logic [11:0] pat);
        logic is_wr;
        wr_req_en = 1'b1; rd_req_en = 1'b1;
        #1;
        checks++; if (sched_state !== 2'd0) begin errors++; $display("FAIL %s_idle got=%0d exp=0", name, sched_state); end
        for (int i = 11; i >= 0; i--) begin
            @(posedge clk); #2;
            is_wr = pat[i];
            checks++;
            if (sched_state !== (is_wr ? 2'd1 : 2'd2) || app_en !== 1'b1 || app_wdf_wren !== is_wr ||
                app_addr !== (is_wr ? 32'h0000_1000 : 32'h0000_2000) || app_cmd !== (is_wr ? 3'd0 : 3'd1)) begin
                errors++;
                $display("FAIL %s_cyc%0d got st=%0d en=%b wren=%b addr=%h exp st=%0d en=1 wren=%b", name, 11 - i,
                         sched_state, app_en, app_wdf_wren, app_addr, is_wr ? 1 : 2, is_wr);
            end
        end
        checks++; if (app_wdf_data !== 32'hA5A5_0001 || app_wdf_mask !== 4'h3) begin errors++; $display("FAIL %s_wdata got=%h/%h exp=a5a50001/3", name, app_wdf_data, app_wdf_mask); end
    endtask

    task automatic test_burst_interleave();
        do_reset();
        wr_burst_max = 8'd4; rd_burst_max = 8'd2;
        run_pattern("interleave", 12'b1111_0011_1100);
    endtask

    task automatic test_zero_max();
        do_reset();
        wr_burst_max = 8'd0; rd_burst_max = 8'd0;
        run_pattern("zero_max", 12'b1010_1010_1010);
    endtask

    task automatic test_read_only();
        do_reset();
        rd_burst_max = 8'd3; rd_req_en = 1'b1;
        #1;
        checks++; if (sched_state !== 2'd0) begin errors++; $display("FAIL rdonly_idle got=%0d exp=0", sched_state); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            checks++;
            if (sched_state !== 2'd2 || app_en !== 1'b1 || rd_req_rdy !== 1'b1 || app_wdf_wren !== 1'b0 || app_addr !== 32'h0000_2000) begin
                errors++;
                $display("FAIL rdonly_cyc%0d got st=%0d en=%b rdy=%b wren=%b exp st=2 en=1 rdy=1 wren=0", i, sched_state, app_en, rd_req_rdy, app_wdf_wren);
            end
        end
    endtask

    task automatic test_starvation();
        do_reset();
        wr_burst_max = 8'd255; rd_burst_max = 8'd1; starve_limit = 8'd5;
        app_wdf_rdy = 1'b0; wr_req_en = 1'b1; rd_req_en = 1'b1;
        #1;
        checks++; if (sched_state !== 2'd0) begin errors++; $display("FAIL starve_idle got=%0d exp=0", sched_state); end
        // starve_cnt reads 0..5 across six WR cycles; the sixth meets the limit
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            checks++;
            if (sched_state !== 2'd1 || app_en !== 1'b0 || wr_req_rdy !== 1'b0) begin
                errors++;
                $display("FAIL starve_wr%0d got st=%0d en=%b rdy=%b exp st=1 en=0 rdy=0", i, sched_state, app_en, wr_req_rdy);
            end
        end
        @(posedge clk); #2;
        checks++; if (sched_state !== 2'd2 || app_en !== 1'b1 || app_wdf_wren !== 1'b0) begin errors++; $display("FAIL starve_switch got st=%0d en=%b wren=%b exp st=2 en=1 wren=0", sched_state, app_en, app_wdf_wren); end
    endtask

    task automatic test_tie_break();
        do_reset();
        wr_req_en = 1'b1; rd_req_en = 1'b1;
        #1;
        checks++; if (sched_state !== 2'd0) begin errors++; $display("FAIL tie_idle got=%0d exp=0", sched_state); end
        @(posedge clk); #1;
        wr_req_en = 1'b0; rd_req_en = 1'b0;
        #1;
        checks++; if (sched_state !== 2'd1) begin errors++; $display("FAIL tie_first got=%0d exp=1", sched_state); end
        @(posedge clk); #1;
        wr_req_en = 1'b1; rd_req_en = 1'b1;
        #1;
        checks++; if (sched_state !== 2'd0) begin errors++; $display("FAIL tie_back_idle got=%0d exp=0", sched_state); end
        @(posedge clk); #2;
        checks++; if (sched_state !== 2'd2) begin errors++; $display("FAIL tie_second got=%0d exp=2", sched_state); end
    endtask

    task automatic test_calib_drop();
        do_reset();
        wr_burst_max = 8'd8; wr_req_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        checks++; if (sched_state !== 2'd1 || app_en !== 1'b1) begin errors++; $display("FAIL calib_burst got st=%0d en=%b exp st=1 en=1", sched_state, app_en); end
        #1 init_calib_complete_r = 1'b0;
        #1;
        checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0) begin errors++; $display("FAIL calib_gate got en=%b wren=%b exp 0 0", app_en, app_wdf_wren); end
        @(posedge clk); #2;
        checks++; if (sched_state !== 2'd0 || app_en !== 1'b0) begin errors++; $display("FAIL calib_idle got st=%0d en=%b exp st=0 en=0", sched_state, app_en); end
        checks++; if (u_dut.burst_cnt !== 8'd0 || u_dut.starve_cnt !== 8'd0) begin errors++; $display("FAIL calib_cnt got b=%0d s=%0d exp 0 0", u_dut.burst_cnt, u_dut.starve_cnt); end
        init_calib_complete_r = 1'b1;
        #1;
        checks++; if (sched_state !== 2'd0) begin errors++; $display("FAIL calib_resume_idle got=%0d exp=0", sched_state); end
        @(posedge clk); #2;
        checks++; if (sched_state !== 2'd1 || app_en !== 1'b1) begin errors++; $display("FAIL calib_resume got st=%0d en=%b exp st=1 en=1", sched_state, app_en); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        rd_req_en = 1'b1;
        @(posedge clk); #2;
        checks++; if (sched_state !== 2'd2 || rd_req_rdy !== 1'b1) begin errors++; $display("FAIL rstrd_pre got st=%0d rdy=%b exp st=2 rdy=1", sched_state, rd_req_rdy); end
        rst = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (sched_state !== 2'd0 || app_en !== 1'b0 || rd_req_rdy !== 1'b0 || wr_req_rdy !== 1'b0 ||
            app_cmd !== 3'd0 || app_addr !== 32'd0 || app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0) begin
            errors++;
            $display("FAIL rstrd_post got st=%0d en=%b rdy=%b%b cmd=%0d addr=%h wren=%b exp all 0", sched_state, app_en,
                     wr_req_rdy, rd_req_rdy, app_cmd, app_addr, app_wdf_wren);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst_interleave();
        test_zero_max();
        test_read_only();
        test_starvation();
        test_tie_break();
        test_calib_drop();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
